// File: rtl/of_action_sync.sv
// Pairs buffered packets with matcher actions (in packet order) and forwards or drops each packet.
// Optional statistics counters are enabled by defining OF_ACTION_SYNC_STATS_EN.
module of_action_sync #(
  parameter int DATA_WIDTH          = 64,
  parameter int CTRL_WIDTH          = 8,
  parameter int ACT_DATA_WIDTH      = 320,
  parameter int ACT_CTRL_WIDTH      = 8,
  parameter int PKT_FIFO_DEPTH_BITS = 9,
  parameter int ACT_FIFO_DEPTH_BITS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [CTRL_WIDTH-1:0]     in_ctrl,
  input  logic                      in_wr,
  output logic                      in_rdy,
  input  logic [ACT_DATA_WIDTH-1:0] action_data_bus,
  input  logic [ACT_CTRL_WIDTH-1:0] action_ctrl_bus,
  input  logic                      action_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0]     out_ctrl,
  output logic                      out_wr,
  input  logic                      out_rdy,
  output logic [ACT_DATA_WIDTH-1:0] out_action_data,
  output logic [ACT_CTRL_WIDTH-1:0] out_action_ctrl,
  output logic                      out_action_valid,
  output logic                      act_overflow,
  output logic [31:0]               pkt_count,
  output logic [31:0]               drop_count
);

  localparam int PKT_W     = CTRL_WIDTH + DATA_WIDTH;
  localparam int ACT_W     = ACT_CTRL_WIDTH + ACT_DATA_WIDTH;
  localparam int PKT_DEPTH = 1 << PKT_FIFO_DEPTH_BITS;
  localparam int ACT_DEPTH = 1 << ACT_FIFO_DEPTH_BITS;
  localparam logic [PKT_FIFO_DEPTH_BITS:0] PKT_FULL_LVL = (PKT_FIFO_DEPTH_BITS+1)'(PKT_DEPTH);
  localparam logic [PKT_FIFO_DEPTH_BITS:0] PKT_NF_LVL   = (PKT_FIFO_DEPTH_BITS+1)'(PKT_DEPTH - 4);
  localparam logic [ACT_FIFO_DEPTH_BITS:0] ACT_FULL_LVL = (ACT_FIFO_DEPTH_BITS+1)'(ACT_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACT = 2'd1, FWD = 2'd2, DISCARD = 2'd3} state_t;

  state_t state_r, state_nxt_s;

  logic [PKT_W-1:0]               pkt_mem_r [PKT_DEPTH];
  logic [PKT_FIFO_DEPTH_BITS-1:0] pkt_wptr_r, pkt_rptr_r;
  logic [PKT_FIFO_DEPTH_BITS:0]   pkt_cnt_r;
  logic [ACT_W-1:0]               act_mem_r [ACT_DEPTH];
  logic [ACT_FIFO_DEPTH_BITS-1:0] act_wptr_r, act_rptr_r;
  logic [ACT_FIFO_DEPTH_BITS:0]   act_cnt_r;

  logic                      pkt_empty_s, pkt_full_s, pkt_push_s, pkt_pop_s;
  logic                      act_empty_s, act_full_s, act_push_s, act_pop_s, act_fwd_pop_s;
  logic [PKT_W-1:0]          pkt_head_s;
  logic [ACT_W-1:0]          act_head_s;
  logic [CTRL_WIDTH-1:0]     head_ctrl_s;
  logic                      eop_s, out_wr_s;
  logic                      prev_zero_r, first_r, act_overflow_r;
  logic [ACT_DATA_WIDTH-1:0] act_data_r;
  logic [ACT_CTRL_WIDTH-1:0] act_ctrl_r;

  assign pkt_empty_s = (pkt_cnt_r == {(PKT_FIFO_DEPTH_BITS+1){1'b0}});
  assign pkt_full_s  = (pkt_cnt_r == PKT_FULL_LVL);
  assign pkt_push_s  = in_wr && !pkt_full_s;
  assign pkt_head_s  = pkt_mem_r[pkt_rptr_r];
  assign head_ctrl_s = pkt_head_s[PKT_W-1 -: CTRL_WIDTH];
  assign act_empty_s = (act_cnt_r == {(ACT_FIFO_DEPTH_BITS+1){1'b0}});
  assign act_full_s  = (act_cnt_r == ACT_FULL_LVL);
  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted then.
  assign act_push_s  = action_valid && (!act_full_s || act_pop_s);
  assign act_head_s  = act_mem_r[act_rptr_r];
  assign eop_s       = pkt_pop_s && (head_ctrl_s != {CTRL_WIDTH{1'b0}}) && prev_zero_r;

  // Packet FIFO storage.
  always_ff @(posedge clk) begin
    if (pkt_push_s) pkt_mem_r[pkt_wptr_r] <= {in_ctrl, in_data};
  end

  // Packet FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_wptr_r <= {PKT_FIFO_DEPTH_BITS{1'b0}};
      pkt_rptr_r <= {PKT_FIFO_DEPTH_BITS{1'b0}};
      pkt_cnt_r  <= {(PKT_FIFO_DEPTH_BITS+1){1'b0}};
    end else begin
      if (pkt_push_s) pkt_wptr_r <= pkt_wptr_r + PKT_FIFO_DEPTH_BITS'(1);
      if (pkt_pop_s)  pkt_rptr_r <= pkt_rptr_r + PKT_FIFO_DEPTH_BITS'(1);
      case ({pkt_push_s, pkt_pop_s})
        2'b10:   pkt_cnt_r <= pkt_cnt_r + (PKT_FIFO_DEPTH_BITS+1)'(1);
        2'b01:   pkt_cnt_r <= pkt_cnt_r - (PKT_FIFO_DEPTH_BITS+1)'(1);
        default: pkt_cnt_r <= pkt_cnt_r;
      endcase
    end
  end

  // Action FIFO storage.
  always_ff @(posedge clk) begin
    if (act_push_s) act_mem_r[act_wptr_r] <= {action_ctrl_bus, action_data_bus};
  end

  // Action FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_wptr_r     <= {ACT_FIFO_DEPTH_BITS{1'b0}};
      act_rptr_r     <= {ACT_FIFO_DEPTH_BITS{1'b0}};
      act_cnt_r      <= {(ACT_FIFO_DEPTH_BITS+1){1'b0}};
      act_overflow_r <= 1'b0;
    end else begin
      if (act_push_s) act_wptr_r <= act_wptr_r + ACT_FIFO_DEPTH_BITS'(1);
      if (act_pop_s)  act_rptr_r <= act_rptr_r + ACT_FIFO_DEPTH_BITS'(1);
      case ({act_push_s, act_pop_s})
        2'b10:   act_cnt_r <= act_cnt_r + (ACT_FIFO_DEPTH_BITS+1)'(1);
        2'b01:   act_cnt_r <= act_cnt_r - (ACT_FIFO_DEPTH_BITS+1)'(1);
        default: act_cnt_r <= act_cnt_r;
      endcase
      if (action_valid && !act_push_s) act_overflow_r <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state logic; the action entry stays queued until the first packet word moves.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!pkt_empty_s) state_nxt_s = WAIT_ACT;
        else              state_nxt_s = IDLE;
      end
      WAIT_ACT: begin
        if (act_empty_s)        state_nxt_s = WAIT_ACT;
        else if (act_head_s[ACT_DATA_WIDTH]) state_nxt_s = DISCARD;
        else                    state_nxt_s = FWD;
      end
      FWD, DISCARD: begin
        if (eop_s) state_nxt_s = IDLE;
        else       state_nxt_s = state_r;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: word/action pops and the downstream write strobe.
  always_comb begin
    pkt_pop_s     = 1'b0;
    act_pop_s     = 1'b0;
    act_fwd_pop_s = 1'b0;
    out_wr_s      = 1'b0;
    case (state_r)
      FWD: begin
        pkt_pop_s     = out_rdy && !pkt_empty_s;
        out_wr_s      = pkt_pop_s;
        act_pop_s     = pkt_pop_s && first_r && !act_empty_s;
        act_fwd_pop_s = act_pop_s;
      end
      DISCARD: begin
        pkt_pop_s = !pkt_empty_s;
        act_pop_s = pkt_pop_s && first_r && !act_empty_s;
      end
      default: begin
        pkt_pop_s = 1'b0;
      end
    endcase
  end

  // Framing history, first-word flag and the held copy of the forwarded action.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_zero_r <= 1'b0;
      first_r     <= 1'b0;
      act_data_r  <= {ACT_DATA_WIDTH{1'b0}};
      act_ctrl_r  <= {ACT_CTRL_WIDTH{1'b0}};
    end else begin
      if (pkt_pop_s) prev_zero_r <= (head_ctrl_s == {CTRL_WIDTH{1'b0}});
      if (state_r == WAIT_ACT && !act_empty_s) first_r <= 1'b1;
      else if (pkt_pop_s)                      first_r <= 1'b0;
      if (act_fwd_pop_s) begin
        act_data_r <= act_head_s[ACT_DATA_WIDTH-1:0];
        act_ctrl_r <= act_head_s[ACT_W-1 -: ACT_CTRL_WIDTH];
      end
    end
  end

  assign in_rdy           = (pkt_cnt_r < PKT_NF_LVL);
  assign out_wr           = out_wr_s;
  assign out_data         = out_wr_s ? pkt_head_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
  assign out_ctrl         = out_wr_s ? head_ctrl_s : {CTRL_WIDTH{1'b0}};
  assign out_action_valid = act_fwd_pop_s;
  assign out_action_data  = act_fwd_pop_s ? act_head_s[ACT_DATA_WIDTH-1:0] : act_data_r;
  assign out_action_ctrl  = act_fwd_pop_s ? act_head_s[ACT_W-1 -: ACT_CTRL_WIDTH] : act_ctrl_r;
  assign act_overflow     = act_overflow_r;

`ifdef OF_ACTION_SYNC_STATS_EN
  logic [31:0] pkt_count_r, drop_count_r;

  // Forwarded and dropped packet counters, counted on the EOP word; they wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_r  <= 32'd0;
      drop_count_r <= 32'd0;
    end else if (eop_s) begin
      if (state_r == FWD) pkt_count_r  <= pkt_count_r + 32'd1;
      else                drop_count_r <= drop_count_r + 32'd1;
    end
  end

  assign pkt_count  = pkt_count_r;
  assign drop_count = drop_count_r;
`else
  assign pkt_count  = 32'd0;
  assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_of_action_sync.sv
// Directed bench for of_action_sync: a packet/action pairing model predicts every forwarded word.
module tb_of_action_sync;

`ifdef OF_ACTION_SYNC_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  in_data;
  logic [7:0]   in_ctrl;
  logic         in_wr;
  logic         in_rdy;
  logic [319:0] action_data_bus;
  logic [7:0]   action_ctrl_bus;
  logic         action_valid;
  logic [63:0]  out_data;
  logic [7:0]   out_ctrl;
  logic         out_wr;
  logic         out_rdy;
  logic [319:0] out_action_data;
  logic [7:0]   out_action_ctrl;
  logic         out_action_valid;
  logic         act_overflow;
  logic [31:0]  pkt_count;
  logic [31:0]  drop_count;

  of_action_sync dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .action_data_bus(action_data_bus), .action_ctrl_bus(action_ctrl_bus), .action_valid(action_valid),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .out_action_data(out_action_data), .out_action_ctrl(out_action_ctrl), .out_action_valid(out_action_valid),
    .act_overflow(act_overflow), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int words_seen = 0;
  int first_wr_cyc = -1;
  logic [319:0] last_first_act = '0;
  logic toggle_rdy = 1'b0;

  // model state
  logic [71:0]  mw_q[$];
  logic [71:0]  exp_w_q[$];
  logic         exp_first_q[$];
  logic [327:0] exp_act_q[$];
  int exp_pkt = 0;
  int exp_drop = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_rdy) out_rdy = ~out_rdy;
  endtask

  task automatic flush_model();
    mw_q.delete();
    exp_w_q.delete();
    exp_first_q.delete();
    exp_act_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_model();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic put_word(input logic [7:0] c, input logic [63:0] d);
    in_wr = 1'b1;
    in_ctrl = c;
    in_data = d;
    mw_q.push_back({c, d});
    tick();
    in_wr = 1'b0;
  endtask

  // header FF, n data words ctrl 00, end word ctrl 01
  task automatic put_pkt(input int n, input logic [7:0] tag);
    put_word(8'hFF, {tag, 56'h0});
    for (int i = 0; i < n; i++) put_word(8'h00, {tag, 24'h0, 32'(i + 1)});
    put_word(8'h01, {tag, 56'hE0D});
  endtask

  // pair the oldest buffered packet with this action
  task automatic model_pair(input logic [7:0] c, input logic [319:0] d);
    logic pz = 1'b0;
    logic first = 1'b1;
    logic done = 1'b0;
    logic [71:0] w;
    while (!done && mw_q.size() > 0) begin
      w = mw_q.pop_front();
      done = (w[71:64] != 8'h00) && pz;
      pz = (w[71:64] == 8'h00);
      if (!c[0]) begin
        exp_w_q.push_back(w);
        exp_first_q.push_back(first);
        exp_act_q.push_back({c, d});
      end
      first = 1'b0;
    end
    if (c[0]) exp_drop++;
    else      exp_pkt++;
  endtask

  task automatic send_act(input logic [7:0] c, input logic [319:0] d);
    action_valid = 1'b1;
    action_ctrl_bus = c;
    action_data_bus = d;
    model_pair(c, d);
    tick();
    action_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_w_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    repeat (10) tick();
    chk("drain_expected_left", exp_w_q.size(), 0);
  endtask

  // compare process: every emitted word checked against the model
  always @(negedge clk) begin
    if (!reset) begin
      if (out_wr) begin
        words_seen++;
        if (exp_w_q.size() == 0) begin
          chk("unexpected_word", {out_ctrl, out_data}, 72'h0);
        end else begin
          logic [71:0]  ew;
          logic         ef;
          logic [327:0] ea;
          ew = exp_w_q.pop_front();
          ef = exp_first_q.pop_front();
          ea = exp_act_q.pop_front();
          chk("out_word", {out_ctrl, out_data}, ew);
          chk("out_action_valid", out_action_valid, ef);
          if (ef) begin
            chk("out_action", {out_action_ctrl, out_action_data}, ea);
            first_wr_cyc = cyc;
            last_first_act = out_action_data;
          end
        end
      end else begin
        chk("idle_action_valid", out_action_valid, 1'b0);
      end
    end
  end

  initial begin
    int base, k, n;
    reset = 1'b1;
    in_wr = 1'b0; in_ctrl = '0; in_data = '0;
    action_valid = 1'b0; action_ctrl_bus = '0; action_data_bus = '0;
    out_rdy = 1'b1;
    do_reset();
    chk("rst_out_wr", out_wr, 1'b0);
    chk("rst_in_rdy", in_rdy, 1'b1);
    chk("rst_overflow", act_overflow, 1'b0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_out_action_data", out_action_data, 320'd0);

    // 1: forward one packet
    base = words_seen;
    put_pkt(3, 8'h11);
    send_act(8'h00, {40{8'hA5}});
    drain();
    chk("t1_words", words_seen - base, 5);
    chk("t1_act_data", last_first_act, {40{8'hA5}});
    chk("t1_pkt_count", pkt_count, STATS);
    chk("t1_held_act", out_action_data, {40{8'hA5}});

    // 2: drop one packet
    do_reset();
    base = words_seen;
    put_pkt(3, 8'h22);
    send_act(8'h01, {40{8'h5A}});
    drain();
    chk("t2_words", words_seen - base, 0);
    chk("t2_drop_count", drop_count, STATS);
    chk("t2_pkt_count", pkt_count, 32'd0);
    chk("t2_in_rdy", in_rdy, 1'b1);

    // 3: action late; first word exactly two edges after the action is sampled
    do_reset();
    base = words_seen;
    put_pkt(2, 8'h33);
    repeat (20) tick();
    chk("t3_no_early_wr", words_seen - base, 0);
    k = cyc;
    send_act(8'h00, {40{8'h3C}});
    drain();
    chk("t3_latency", first_wr_cyc, k + 2);
    chk("t3_words", words_seen - base, 4);

    // 4: fwd/drop/fwd with out_rdy toggling
    do_reset();
    base = words_seen;
    toggle_rdy = 1'b1;
    put_pkt(2, 8'h41);
    put_pkt(3, 8'h42);
    put_pkt(1, 8'h43);
    send_act(8'h00, {40{8'h01}});
    send_act(8'h01, {40{8'h02}});
    send_act(8'h00, {40{8'h03}});
    drain();
    toggle_rdy = 1'b0;
    out_rdy = 1'b1;
    chk("t4_words", words_seen - base, 7);
    chk("t4_last_act", last_first_act, {40{8'h03}});
    chk("t4_pkt_count", pkt_count, 2 * STATS);
    chk("t4_drop_count", drop_count, STATS);

    // 5: action FIFO overflow is sticky
    do_reset();
    action_valid = 1'b1;
    action_ctrl_bus = 8'h00;
    action_data_bus = {40{8'h77}};
    repeat (8) tick();
    chk("t5_no_overflow_at_8", act_overflow, 1'b0);
    tick();
    action_valid = 1'b0;
    chk("t5_overflow_at_9", act_overflow, 1'b1);
    repeat (5) tick();
    chk("t5_overflow_sticky", act_overflow, 1'b1);

    // 6: reset in the middle of forwarding, then a clean packet
    do_reset();
    chk("t6_overflow_cleared", act_overflow, 1'b0);
    base = words_seen;
    put_pkt(5, 8'h66);
    send_act(8'h00, {40{8'h66}});
    n = 0;
    while (words_seen < base + 3 && n < 200) begin
      tick();
      n++;
    end
    chk("t6_reached_word3", (words_seen >= base + 3), 1'b1);
    reset = 1'b1;
    flush_model();
    tick();
    @(negedge clk);
    chk("t6_out_wr", out_wr, 1'b0);
    chk("t6_in_rdy", in_rdy, 1'b1);
    chk("t6_out_action_valid", out_action_valid, 1'b0);
    chk("t6_out_action_data", out_action_data, 320'd0);
    chk("t6_out_data", out_data, 64'd0);
    chk("t6_pkt_count", pkt_count, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    base = words_seen;
    put_pkt(3, 8'h67);
    send_act(8'h00, {40{8'hA5}});
    drain();
    chk("t6_clean_words", words_seen - base, 5);
    chk("t6_clean_act", last_first_act, {40{8'hA5}});
    chk("t6_clean_pkt_count", pkt_count, STATS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
